minmax_scan_ctrl: RTL and testbench



---
 rtl/minmax_pkg.sv | 21 ++
 rtl/minmax_scan_ctrl_if.sv | 40 ++++
 rtl/mag_cmp4.sv | 16 +
 rtl/minmax_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_minmax_scan_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max burst scanner.
package minmax_pkg;

    localparam int unsigned DATA_W        = 4;
    localparam int unsigned BURST_LEN_MAX = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CMP_MAX,
        S_CMP_MIN,
        S_OUT
    } state_e;

    // Burst length must be legal and the sample counter must be able to reach it.
    function automatic bit burst_cfg_ok(int unsigned burst_len, int unsigned cnt_w);
        return (burst_len >= 1) && (burst_len <= BURST_LEN_MAX) && (cnt_w < 32) &&
               (burst_len < (32'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/minmax_scan_ctrl_if.sv
// Sample-in / result-out handshake bundle for minmax_scan_ctrl.
// max_count exists only when MINMAX_TIE_COUNT_EN is defined.
interface minmax_scan_ctrl_if
`ifdef MINMAX_TIE_COUNT_EN
    #(parameter int unsigned CNT_W = 4)
`endif
    ;

    logic                              in_valid;
    logic                              in_ready;
    logic [minmax_pkg::DATA_W-1:0]     in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [minmax_pkg::DATA_W-1:0]     min_out;
    logic [minmax_pkg::DATA_W-1:0]     max_out;
`ifdef MINMAX_TIE_COUNT_EN
    logic [CNT_W-1:0]                  max_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, min_out, max_out, max_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, min_out, max_out, max_count
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, min_out, max_out
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, min_out, max_out
    );
`endif

endinterface

// File: rtl/mag_cmp4.sv
// Combinational 4-bit unsigned magnitude comparator; exactly one output is high.
module mag_cmp4
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              less,
    output logic              equal,
    output logic              greater
);

    assign less    = (a < b);
    assign equal   = (a == b);
    assign greater = (a > b);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Streaming per-burst min/max scanner sharing one comparator across two compare states.
// Optional tie counter (max_count) enabled by MINMAX_TIE_COUNT_EN.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    minmax_scan_ctrl_if.slave  bus
);

    if (!burst_cfg_ok(BURST_LEN, CNT_W)) begin : g_cfg_err
        $error("minmax_scan_ctrl: BURST_LEN must be 1..15 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_LEN);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   samp_q, samp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef MINMAX_TIE_COUNT_EN
    logic [CNT_W-1:0]    tie_q, tie_d;
`endif

    logic                in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   cmp_b;
    logic                cmp_lt, cmp_eq, cmp_gt;

    // Operand B follows the compare state; only S_CMP_MIN looks at the running minimum.
    assign cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;

    mag_cmp4 u_cmp (
        .a       (samp_q),
        .b       (cmp_b),
        .less    (cmp_lt),
        .equal   (cmp_eq),
        .greater (cmp_gt)
    );

`ifndef MINMAX_TIE_COUNT_EN
    logic unused_cmp_eq;
    assign unused_cmp_eq = cmp_eq;
`endif

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        samp_d    = samp_q;
        cnt_d     = cnt_q;
`ifdef MINMAX_TIE_COUNT_EN
        tie_d     = tie_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    min_d = bus.in_data;
                    max_d = bus.in_data;
                    cnt_d = CNT_W'(1);
`ifdef MINMAX_TIE_COUNT_EN
                    tie_d = CNT_W'(1);
`endif
                    state_d = (BURST_LEN == 1) ? S_OUT : S_WAIT;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    samp_d  = bus.in_data;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_CMP_MAX;
                end
            end
            S_CMP_MAX: begin
                if (cmp_gt) begin
                    max_d = samp_q;
`ifdef MINMAX_TIE_COUNT_EN
                    tie_d = CNT_W'(1);
                end else if (cmp_eq) begin
                    tie_d = tie_q + CNT_W'(1);
`endif
                end
                state_d = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                if (cmp_lt) begin
                    min_d = samp_q;
                end
                state_d = (cnt_q == BurstLast) ? S_OUT : S_WAIT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            samp_q  <= '0;
            cnt_q   <= '0;
`ifdef MINMAX_TIE_COUNT_EN
            tie_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
`ifdef MINMAX_TIE_COUNT_EN
            tie_q   <= tie_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.min_out   = min_q;
    assign bus.max_out   = max_q;
`ifdef MINMAX_TIE_COUNT_EN
    assign bus.max_count = tie_q;
`endif

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Scoreboard bench for minmax_scan_ctrl: bursts are modelled as plain sample lists,
// results are popped and compared by an independent output monitor.
module tb_minmax_scan_ctrl;
    import minmax_pkg::*;

    localparam int unsigned BL    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned BOUND = 40;

    typedef logic [DATA_W-1:0] samp_t;
    typedef samp_t sq_t[$];
    typedef struct packed {
        samp_t           mn;
        samp_t           mx;
        logic [CW-1:0]   cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

`ifdef MINMAX_TIE_COUNT_EN
    minmax_scan_ctrl_if #(.CNT_W(CW)) bus ();
    minmax_scan_ctrl_if #(.CNT_W(CW)) bus1 ();
`else
    minmax_scan_ctrl_if bus ();
    minmax_scan_ctrl_if bus1 ();
`endif

    minmax_scan_ctrl #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    minmax_scan_ctrl #(.BURST_LEN(1), .CNT_W(CW)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: extrema and tie count straight from the sample list.
    function automatic exp_t model(input sq_t s);
        exp_t e;
        e.mn  = s[0];
        e.mx  = s[0];
        e.cnt = '0;
        foreach (s[i]) begin
            if (s[i] < e.mn) e.mn = s[i];
            if (s[i] > e.mx) e.mx = s[i];
        end
        foreach (s[i]) if (s[i] == e.mx) e.cnt = e.cnt + 1'b1;
        return e;
    endfunction

    function automatic sq_t unpack8(input logic [31:0] pat);
        sq_t q;
        for (int i = 7; i >= 0; i--) q.push_back(pat[i*4 +: 4]);
        return q;
    endfunction

    function automatic sq_t rand_burst();
        sq_t q;
        int unsigned hi;
        hi = $urandom_range(0, 1) ? 15 : 3;
        for (int i = 0; i < 8; i++) q.push_back(samp_t'($urandom_range(0, hi)));
        return q;
    endfunction

    // Entered and left just after a rising edge.
    task automatic accept_one(input samp_t d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < BOUND);
        if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from accept until in_ready (or out_valid) returns; junk in_valid must be ignored.
    task automatic expect_latency(input string name, input bit for_out, input int req);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < BOUND) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = samp_t'($urandom);
            @(negedge clk);
            lat++;
            seen = for_out ? bus.out_valid : bus.in_ready;
        end
        bus.in_valid = 1'b0;
        check(name, lat, req);
    endtask

    task automatic send_burst(input sq_t s, input int gap_max);
        exp_q.push_back(model(s));
        foreach (s[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            accept_one(s[i]);
            expect_latency($sformatf("latency_s%0d", i), i == s.size() - 1, (i == 0) ? 1 : 3);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int stall);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // Output monitor: stability under backpressure, result compare, post-handshake state.
    initial begin
        exp_t e;
        exp_t held;
        bit   holding;
        bit   post_hs;
        holding = 1'b0;
        post_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                holding = 1'b0;
                post_hs = 1'b0;
            end else begin
                if (post_hs) begin
                    check("post_hs_out_valid", bus.out_valid, 0);
                    check("post_hs_in_ready", bus.in_ready, 1);
                    post_hs = 1'b0;
                end
                if (bus.out_valid) begin
                    check("in_ready_in_out", bus.in_ready, 0);
                    if (!holding) begin
                        holding = 1'b1;
                        held.mn = bus.min_out;
                        held.mx = bus.max_out;
`ifdef MINMAX_TIE_COUNT_EN
                        held.cnt = bus.max_count;
`endif
                    end else begin
                        check("stall_min_stable", bus.min_out, held.mn);
                        check("stall_max_stable", bus.max_out, held.mx);
`ifdef MINMAX_TIE_COUNT_EN
                        check("stall_count_stable", bus.max_count, held.cnt);
`endif
                    end
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_result: got min=%0d max=%0d, required none",
                                     bus.min_out, bus.max_out);
                        end else begin
                            e = exp_q.pop_front();
                            check("min_out", bus.min_out, e.mn);
                            check("max_out", bus.max_out, e.mx);
`ifdef MINMAX_TIE_COUNT_EN
                            check("max_count", bus.max_count, e.cnt);
`endif
                        end
                        holding = 1'b0;
                        post_hs = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_min_out", bus.min_out, 0);
        check("rst_max_out", bus.max_out, 0);
`ifdef MINMAX_TIE_COUNT_EN
        check("rst_max_count", bus.max_count, 0);
`endif
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send_burst(unpack8(32'h3919_50F7), 0);
        send_burst(unpack8(32'h6666_6666), 0);

        bus.out_ready = 1'b0;
        send_burst(unpack8(32'h2CC4_C113), 3);
        drain(10);

        // Reset while the second sample is in S_CMP_MIN.
        bus.out_ready = 1'b1;
        accept_one(4'd5);
        expect_latency("rst_burst_lat0", 1'b0, 1);
        @(posedge clk);
        #1;
        accept_one(4'd11);
        @(negedge clk);
        check("cmp_max_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("cmp_min_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_min_out", bus.min_out, 0);
        check("midrst_max_out", bus.max_out, 0);
        @(posedge clk);
        #1;
        send_burst(unpack8(32'h0123_4567), 0);

        // Single-sample bursts.
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'd10;
        @(negedge clk);
        check("bl1_in_ready", bus1.in_ready, 1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("bl1_out_valid", bus1.out_valid, 1);
        check("bl1_in_ready_out", bus1.in_ready, 0);
        check("bl1_min_out", bus1.min_out, 10);
        check("bl1_max_out", bus1.max_out, 10);
`ifdef MINMAX_TIE_COUNT_EN
        check("bl1_max_count", bus1.max_count, 1);
`endif
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        check("bl1_post_out_valid", bus1.out_valid, 0);
        check("bl1_post_in_ready", bus1.in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int b = 0; b < 6; b++) send_burst(rand_burst(), 0);

        // Random producer gaps and consumer stalls.
        bus.out_ready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            send_burst(rand_burst(), 2);
            drain($urandom_range(0, 6));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
